// File: rtl/alu_driver.sv
// alu_driver: request/response front end for the 6-bit ALU test wrapper.
// Takes one (a, b, func) request, loads the three wrapper registers in turn
// over en/sel/x, waits out the wrapper's result latency, captures y/of and
// presents them on the response channel. One operation is in flight at a time.
module alu_driver #(
   parameter int WAIT_CYCLES = 1,   // legal range 1..15
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [5:0]       req_a,
   input  logic [5:0]       req_b,
   input  logic [3:0]       req_func,
   output logic             en,
   output logic [1:0]       sel,
   output logic [5:0]       x,
   input  logic [5:0]       y,
   input  logic             of,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [5:0]       rsp_y,
   output logic             rsp_of,
   output logic             busy,
   output logic [CNT_W-1:0] op_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD_A,
      S_LD_B,
      S_LD_F,
      S_WAIT,
      S_CAPT,
      S_RESP
   } state_t;

   localparam logic [1:0]       SEL_A    = 2'b00;
   localparam logic [1:0]       SEL_B    = 2'b01;
   localparam logic [1:0]       SEL_F    = 2'b10;
   localparam logic [1:0]       SEL_NONE = 2'b11;
   localparam logic [3:0]       WAIT_LD  = 4'(WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   logic [5:0]       r_a_hold;
   logic [5:0]       r_b_hold;
   logic [3:0]       r_f_hold;
   logic [3:0]       r_wait;
   logic             r_en;
   logic [1:0]       r_sel;
   logic [5:0]       r_x;
   logic             r_rsp_valid;
   logic [5:0]       r_rsp_y;
   logic             r_rsp_of;
   logic             r_busy;
   logic [CNT_W-1:0] r_op_cnt;

   // Sequencer: the wrapper-side outputs are set on the edge that enters a
   // state, so en/sel/x always describe the state currently held.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_a_hold    <= '0;
         r_b_hold    <= '0;
         r_f_hold    <= '0;
         r_wait      <= '0;
         r_en        <= 1'b0;
         r_sel       <= SEL_NONE;
         r_x         <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_y     <= '0;
         r_rsp_of    <= 1'b0;
         r_busy      <= 1'b0;
         r_op_cnt    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_a_hold <= req_a;
                  r_b_hold <= req_b;
                  r_f_hold <= req_func;
                  r_en     <= 1'b1;
                  r_sel    <= SEL_A;
                  r_x      <= req_a;
                  r_busy   <= 1'b1;
                  r_state  <= S_LD_A;
               end
            end
            S_LD_A: begin
               r_sel   <= SEL_B;
               r_x     <= r_b_hold;
               r_state <= S_LD_B;
            end
            S_LD_B: begin
               r_sel   <= SEL_F;
               r_x     <= {2'b00, r_f_hold};
               r_state <= S_LD_F;
            end
            S_LD_F: begin
               r_en    <= 1'b0;
               r_sel   <= SEL_NONE;
               r_x     <= '0;
               r_wait  <= WAIT_LD;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               // Counter loaded with WAIT_CYCLES-1, so WAIT lasts WAIT_CYCLES cycles.
               if (r_wait == 4'd0) begin
                  r_state <= S_CAPT;
               end else begin
                  r_wait <= r_wait - 4'd1;
               end
            end
            S_CAPT: begin
               r_rsp_y     <= y;
               r_rsp_of    <= of;
               r_rsp_valid <= 1'b1;
               r_state     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_op_cnt    <= r_op_cnt + CNT_ONE;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_en        <= 1'b0;
               r_sel       <= SEL_NONE;
               r_x         <= '0;
               r_rsp_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign en        = r_en;
   assign sel       = r_sel;
   assign x         = r_x;
   assign rsp_valid = r_rsp_valid;
   assign rsp_y     = r_rsp_y;
   assign rsp_of    = r_rsp_of;
   assign busy      = r_busy;
   assign op_cnt    = r_op_cnt;

endmodule

// File: tb/tb_alu_driver.sv
// tb_alu_driver: two driver instances (WAIT_CYCLES=1 and 3), each attached to
// a behavioural model of the ALU wrapper. Results are checked against an
// integer-arithmetic reference of the ALU functions.
module tb_alu_driver;

   logic       clk = 1'b0;
   logic       rstn;
   always #5 clk = ~clk;

   logic       req_valid [2];
   logic       req_ready [2];
   logic [5:0] req_a     [2];
   logic [5:0] req_b     [2];
   logic [3:0] req_func  [2];
   logic       en        [2];
   logic [1:0] sel       [2];
   logic [5:0] x         [2];
   logic [5:0] y         [2];
   logic       of_w      [2];
   logic       rsp_valid [2];
   logic       rsp_ready [2];
   logic [5:0] rsp_y     [2];
   logic       rsp_of    [2];
   logic       busy      [2];
   logic [7:0] op_cnt    [2];

   logic [5:0] wa [2];
   logic [5:0] wb [2];
   logic [3:0] wf [2];

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_cnt [2];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         alu_driver #(.WAIT_CYCLES(gi == 0 ? 1 : 3), .CNT_W(8)) u_dut (
            .clk       (clk),
            .rstn      (rstn),
            .req_valid (req_valid[gi]),
            .req_ready (req_ready[gi]),
            .req_a     (req_a[gi]),
            .req_b     (req_b[gi]),
            .req_func  (req_func[gi]),
            .en        (en[gi]),
            .sel       (sel[gi]),
            .x         (x[gi]),
            .y         (y[gi]),
            .of        (of_w[gi]),
            .rsp_valid (rsp_valid[gi]),
            .rsp_ready (rsp_ready[gi]),
            .rsp_y     (rsp_y[gi]),
            .rsp_of    (rsp_of[gi]),
            .busy      (busy[gi]),
            .op_cnt    (op_cnt[gi])
         );
      end
   endgenerate

   // Wrapper model ALU: {of, y}
   function automatic logic [6:0] wrap_alu(input logic [5:0] a, input logic [5:0] b,
                                           input logic [3:0] f);
      logic [5:0] r;
      logic       o;
      r = '0;
      o = 1'b0;
      case (f)
         4'd0: begin r = a + b; o = (a[5] == b[5]) && (r[5] != a[5]); end
         4'd1: begin r = a - b; o = (a[5] != b[5]) && (r[5] != a[5]); end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         default: r = '0;
      endcase
      return {o, r};
   endfunction

   // Wrapper model: unreset load registers plus one registered result stage
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (en[i]) begin
            case (sel[i])
               2'b00:   wa[i] <= x[i];
               2'b01:   wb[i] <= x[i];
               2'b10:   wf[i] <= x[i][3:0];
               default: ;
            endcase
         end
         {of_w[i], y[i]} <= wrap_alu(wa[i], wb[i], wf[i]);
      end
   end

   // Reference: signed integer arithmetic, overflow = result outside -32..31
   function automatic void ref_op(input logic [5:0] a, input logic [5:0] b, input logic [3:0] f,
                                  output logic [5:0] ey, output logic eo);
      int sa, sb, r;
      sa = a[5] ? int'(a) - 64 : int'(a);
      sb = b[5] ? int'(b) - 64 : int'(b);
      eo = 1'b0;
      case (f)
         4'd0: begin r = sa + sb; eo = (r > 31) || (r < -32); end
         4'd1: begin r = sa - sb; eo = (r > 31) || (r < -32); end
         4'd2: r = int'(a & b);
         4'd3: r = int'(a | b);
         4'd4: r = int'(a ^ b);
         default: r = 0;
      endcase
      ey = r[5:0];
   endfunction

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Always-true properties while out of reset
   always @(negedge clk) begin
      if (rstn) begin
         for (int i = 0; i < 2; i++) begin
            check_val("inv_sel_idle", en[i] ? 1 : ((sel[i] == 2'b11) && (x[i] == 6'd0)), 1);
            check_val("inv_busy", busy[i], !req_ready[i]);
         end
      end
   end

   // One full operation on instance k; called at a negedge
   task automatic do_op(input int k, input logic [5:0] a, input logic [5:0] b,
                        input logic [3:0] f, input int stall, input bit early, input bit b2b);
      int         wc;
      int         n;
      logic [5:0] ey;
      logic       eo;
      logic [5:0] held_y;
      wc = (k == 0) ? 1 : 3;
      ref_op(a, b, f, ey, eo);
      req_a[k] = a;
      req_b[k] = b;
      req_func[k] = f;
      req_valid[k] = 1'b1;
      if (b2b) check_val("b2b_ready", req_ready[k], 1);
      n = 0;
      while (!req_ready[k] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready[k]) check_val("req_ready_timeout", 0, 1);
      @(negedge clk);
      if (!b2b) req_valid[k] = 1'b0;
      req_a[k] = 6'($urandom);
      req_b[k] = 6'($urandom);
      req_func[k] = 4'($urandom);
      if (early) rsp_ready[k] = 1'b1;
      check_val("ld_a", {en[k], sel[k], x[k]}, {1'b1, 2'b00, a});
      check_val("busy_ld", busy[k], 1);
      check_val("ready_ld", req_ready[k], 0);
      @(negedge clk);
      check_val("ld_b", {en[k], sel[k], x[k]}, {1'b1, 2'b01, b});
      @(negedge clk);
      check_val("ld_f", {en[k], sel[k], x[k]}, {1'b1, 2'b10, 2'b00, f});
      @(negedge clk);
      n = 3;
      while (!rsp_valid[k] && n < 60) begin
         check_val("wait_en", {en[k], sel[k], x[k]}, {1'b0, 2'b11, 6'd0});
         @(negedge clk);
         n++;
      end
      check_val("latency", n, 4 + wc);
      check_val("rsp_y", rsp_y[k], ey);
      check_val("rsp_of", rsp_of[k], eo);
      held_y = rsp_y[k];
      if (!early) begin
         rsp_ready[k] = 1'b0;
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_val("bp_valid", rsp_valid[k], 1);
            check_val("bp_y", rsp_y[k], held_y);
            check_val("bp_ready", req_ready[k], 0);
            check_val("bp_en", en[k], 0);
            check_val("bp_cnt", op_cnt[k], exp_cnt[k]);
         end
         rsp_ready[k] = 1'b1;
      end
      @(negedge clk);
      exp_cnt[k] = exp_cnt[k] + 8'd1;
      check_val("hs_valid", rsp_valid[k], 0);
      check_val("op_cnt", op_cnt[k], exp_cnt[k]);
      check_val("hs_en", en[k], 0);
      check_val("hs_ready", req_ready[k], 1);
      if (!early) rsp_ready[k] = 1'b0;
      $display("op k=%0d a=%02h b=%02h f=%0h -> y=%02h of=%0d cnt=%0d", k, a, b, f,
               held_y, rsp_of[k], op_cnt[k]);
   endtask

   logic [7:0] cnt_before;

   initial begin
      for (int i = 0; i < 2; i++) begin
         req_valid[i] = 1'b0;
         req_a[i]     = '0;
         req_b[i]     = '0;
         req_func[i]  = '0;
         rsp_ready[i] = 1'b0;
         exp_cnt[i]   = '0;
      end
      rstn = 1'b1;
      #1 rstn = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check_val("rst_en_sel_x", {en[i], sel[i], x[i]}, {1'b0, 2'b11, 6'd0});
         check_val("rst_rsp", {rsp_valid[i], rsp_y[i], rsp_of[i]}, 0);
         check_val("rst_cnt", op_cnt[i], 0);
         check_val("rst_busy", busy[i], 0);
         check_val("rst_ready", req_ready[i], 1);
      end
      rstn = 1'b1;
      @(negedge clk);

      // Basic add and signed overflow, consumer always ready
      do_op(0, 6'h05, 6'h03, 4'h0, 0, 1'b1, 1'b0);
      do_op(0, 6'h1F, 6'h01, 4'h0, 0, 1'b1, 1'b0);
      // Backpressure
      rsp_ready[0] = 1'b0;
      do_op(0, 6'($urandom), 6'($urandom), 4'($urandom_range(0, 4)), 10, 1'b0, 1'b0);
      // Back-to-back with req_valid held high
      rsp_ready[0] = 1'b1;
      do_op(0, 6'h20, 6'h20, 4'h0, 0, 1'b1, 1'b1);
      do_op(0, 6'($urandom), 6'($urandom), 4'($urandom_range(0, 15)), 0, 1'b1, 1'b1);
      req_valid[0] = 1'b0;

      // Reset during LD_B
      rsp_ready[0] = 1'b0;
      req_a[0] = 6'h11;
      req_b[0] = 6'h22;
      req_func[0] = 4'h0;
      req_valid[0] = 1'b1;
      @(negedge clk);
      req_valid[0] = 1'b0;
      @(negedge clk);
      check_val("pre_rst_ld_b", {en[0], sel[0]}, {1'b1, 2'b01});
      #2 rstn = 1'b0;
      #1;
      check_val("arst_en_sel", {en[0], sel[0]}, {1'b0, 2'b11});
      check_val("arst_busy", busy[0], 0);
      check_val("arst_valid", rsp_valid[0], 0);
      check_val("arst_cnt", op_cnt[0], 0);
      exp_cnt[0] = '0;
      exp_cnt[1] = '0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      do_op(0, 6'h2A, 6'h15, 4'h1, 2, 1'b0, 1'b0);

      // WAIT_CYCLES=3 instance
      for (int t = 0; t < 4; t++)
         do_op(1, 6'($urandom), 6'($urandom), 4'($urandom_range(0, 5)),
               int'($urandom_range(0, 3)), 1'b0, 1'b0);

      // Counter wrap: 256 operations bring op_cnt back to its start value
      cnt_before = exp_cnt[0];
      for (int t = 0; t < 256; t++)
         do_op(0, 6'($urandom), 6'($urandom), 4'($urandom_range(0, 4)), 0, 1'b1, 1'b0);
      check_val("cnt_wrap", op_cnt[0], cnt_before);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_driver.md
Name: alu_driver

Overview:
- Initiator for the 6-bit ALU test wrapper's switch-style load interface (en / sel[1:0] / x[5:0] in; registered y[5:0] / of out).
- Accepts a complete operation (a, b, func) over a valid/ready request channel.
- Sequences the three register loads into the wrapper, waits out the wrapper's result-register latency, then returns y/of over a valid/ready response channel.
- Lets scripted benches or a host controller run ALU operations without hand-driving sel/en.

Parameters:
- WAIT_CYCLES, 1, number of cycles with en=0 after the func load before the result is sampled. Legal range 1..15. 1 matches the wrapper's single output register.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rstn  input  1  asynchronous active-low reset
- req_valid  input  1  operation request valid
- req_ready  output  1  driver can accept a request
- req_a  input  6  operand a
- req_b  input  6  operand b
- req_func  input  4  ALU function code
- en  output  1  wrapper load enable
- sel  output  2  wrapper load select: 00=a, 01=b, 10=func, 11=none
- x  output  6  wrapper load data
- y  input  6  wrapper registered result
- of  input  1  wrapper registered overflow
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_y  output  6  captured result
- rsp_of  output  1  captured overflow
- busy  output  1  high in every state except IDLE
- op_cnt  output  CNT_W  completed-operation count

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, en=0, sel=2'b11, x=0, rsp_valid=0, rsp_y=0, rsp_of=0, op_cnt=0, busy=0, request holding registers=0. Reset is honoured in any state; an in-flight operation is dropped with no response.
- All outputs are registered or decoded purely from registered state. No combinational path exists from any input to any output, except that req_ready is decoded from state only.
- States and transitions:
  - IDLE: req_ready=1. On req_valid & req_ready, latch req_a/req_b/req_func into holding registers and go to LD_A.
  - LD_A: en=1, sel=00, x=a_hold. Unconditionally go to LD_B.
  - LD_B: en=1, sel=01, x=b_hold. Unconditionally go to LD_F.
  - LD_F: en=1, sel=10, x={2'b00, func_hold}. Go to WAIT; load the wait counter with WAIT_CYCLES-1.
  - WAIT: en=0, sel=11, x=0. Decrement the counter; go to CAPT when it reaches 0.
  - CAPT: en=0. At the closing edge, rsp_y<=y, rsp_of<=of, rsp_valid<=1; go to RESP.
  - RESP: rsp_valid=1; rsp_y and rsp_of are held stable. On rsp_ready: rsp_valid<=0, op_cnt<=op_cnt+1, go to IDLE.
- req_ready=0 in every non-IDLE state. Requests are not queued, so a new request is accepted no earlier than the cycle after the response handshake.
- Latency: with the request accepted at edge 0, rsp_valid rises after edge 4+WAIT_CYCLES (edge 5 for the default).
- Throughput: one operation per 6+WAIT_CYCLES cycles when rsp_ready is held high.
- All three wrapper registers (a, b, func) are reloaded on every operation, because the wrapper's registers have no reset and their contents are never trusted.
- en is never high outside LD_A/LD_B/LD_F. sel=11 whenever en=0.
- op_cnt wraps from all-ones to 0 with no saturation.
- rsp_ready asserted while rsp_valid=0 has no effect.
- Request inputs are ignored outside IDLE; changes on them do not affect the operation in flight.

Test Plan:
- Bench harness: a behavioural wrapper model with func 0 = 6-bit add, of = signed overflow.
- Basic add: reset, then request a=6'h05, b=6'h03, func=4'h0, rsp_ready=1 -> en/sel/x sequence (1,00,05), (1,01,03), (1,10,00), (0,11,00); rsp_valid rises 5 cycles after acceptance with rsp_y=6'h08, rsp_of=0; op_cnt=1.
- Overflow: a=6'h1F, b=6'h01, func=0 -> rsp_y=6'h20, rsp_of=1.
- Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid stays 1, rsp_y stable, req_ready=0, en=0 throughout; release -> one handshake, op_cnt increments once.
- Back-to-back: two requests with req_valid held high -> second is accepted the cycle after the first response handshake; no en pulse occurs between CAPT and the next LD_A; both results correct.
- Reset mid-operation: assert rstn=0 during LD_B -> en=0, sel=11, busy=0, rsp_valid=0 immediately (asynchronously); after release, a fresh request completes correctly.
- Counter wrap and WAIT_CYCLES=3: run 256 operations with CNT_W=8 -> op_cnt returns to 0. With WAIT_CYCLES=3, latency is 7 cycles.
